// File: rtl/sd_pkg.sv
// Shared definitions for the sigma-delta DAC modulator.
//   DataWDefault / AccWDefault : default sample and integrator widths.
//   FsDefault                  : full-scale magnitude for the default width.
//   acc_t                      : integrator type at the default width.
//   fs_of()                    : full scale 2^(data_w-1) for any sample width.
//   sat_add()                  : signed add clamped to a signed 'width'-bit range.
package sd_pkg;

  localparam int unsigned DataWDefault = 16;
  localparam int unsigned AccWDefault  = DataWDefault + 6;

  typedef logic signed [63:0]              wide_t;
  typedef logic signed [AccWDefault-1:0]   acc_t;

  localparam wide_t FsDefault = 64'sd1 <<< (DataWDefault - 1);

  function automatic wide_t fs_of(input int unsigned data_w);
    return 64'sd1 <<< (data_w - 1);
  endfunction

  // Operands are far narrower than 64 bits, so the wide sum itself never wraps.
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned width);
    wide_t sum;
    wide_t hi;
    wide_t lo;
    sum = a + b;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (width - 1));
    if (sum > hi) begin
      return hi;
    end
    if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/sd_mod2_core.sv
// Second-order CIFB delta-sigma core: two saturating integrators, a 1-bit
// quantizer and +/-FS feedback.
//   clk_i, rst_ni : clock, async active-low reset
//   step_i        : advance the loop by one bit period
//   clear_i       : zero both integrators (idle)
//   toggle_i      : invert the output bit (idle 1010 pattern)
//   x_i           : signed input sample
//   bs_o          : registered output bit, 1 = +FS, 0 = -FS
module sd_mod2_core
  import sd_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned ACC_W  = AccWDefault
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     step_i,
  input  logic                     clear_i,
  input  logic                     toggle_i,
  input  logic signed [DATA_W-1:0] x_i,
  output logic                     bs_o
);

  localparam wide_t Fs = fs_of(DATA_W);

  logic signed [ACC_W-1:0] i1_q, i1_d;
  logic signed [ACC_W-1:0] i2_q, i2_d;
  logic                    bs_q, bs_d;
  wide_t                   x_w, fb, s1, s2;

  always_comb begin
    x_w  = wide_t'(x_i);
    fb   = bs_q ? Fs : -Fs;
    s1   = sat_add(wide_t'(i1_q), x_w - fb, ACC_W);
    // Second integrator is fed from the already-updated first integrator.
    s2   = sat_add(wide_t'(i2_q), s1 - fb, ACC_W);
    i1_d = i1_q;
    i2_d = i2_q;
    bs_d = bs_q;
    if (clear_i) begin
      i1_d = '0;
      i2_d = '0;
    end else if (step_i) begin
      i1_d = ACC_W'(s1);
      i2_d = ACC_W'(s2);
      bs_d = (s2 >= 64'sd0);
    end
    if (toggle_i) begin
      bs_d = ~bs_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      i1_q <= '0;
      i2_q <= '0;
      bs_q <= 1'b0;
    end else begin
      i1_q <= i1_d;
      i2_q <= i2_d;
      bs_q <= bs_d;
    end
  end

  assign bs_o = bs_q;

endmodule

// File: rtl/sd_dac_modulator.sv
// Sigma-delta DAC front end: one-entry sample buffer, OSR phase counter,
// underrun flag and the second-order modulator core.
//   clk_i, rst_ni    : clock, async active-low reset
//   ce_i             : bit-rate tick
//   en_i             : run enable (0 = idle, zero-mean 1010 output)
//   din_i            : signed PCM sample, din_valid_i / din_ready_o handshake
//   bs_o             : 1-bit output stream
//   frame_start_o    : pulse on the tick where a frame begins
//   underrun_o       : sticky, set when a frame begins with no buffered sample
//   clr_underrun_i   : synchronous clear of underrun_o (wins over set)
module sd_dac_modulator
  import sd_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned OSR    = 64,
  parameter int unsigned ACC_W  = DATA_W + 6
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     ce_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] din_i,
  input  logic                     din_valid_i,
  output logic                     din_ready_o,
  output logic                     bs_o,
  output logic                     frame_start_o,
  output logic                     underrun_o,
  input  logic                     clr_underrun_i
);

  localparam int unsigned PhW = (OSR > 1) ? $clog2(OSR) : 1;

  logic [PhW-1:0]           ph_q, ph_d;
  logic                     buf_full_q, buf_full_d;
  logic signed [DATA_W-1:0] nxt_q, nxt_d;
  logic signed [DATA_W-1:0] cur_q, cur_d;
  logic                     underrun_q, underrun_d;
  logic                     run, boundary, accept;

  assign run      = ce_i & en_i;
  assign boundary = run & (ph_q == '0);
  assign accept   = din_valid_i & ~buf_full_q;

  always_comb begin
    buf_full_d = buf_full_q;
    nxt_d      = nxt_q;
    cur_d      = cur_q;
    underrun_d = underrun_q;
    ph_d       = ph_q;

    if (boundary) begin
      if (buf_full_q) begin
        cur_d      = nxt_q;
        buf_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
    end
    // Accept only happens with an empty buffer, so it never races the load above.
    if (accept) begin
      nxt_d      = din_i;
      buf_full_d = 1'b1;
    end
    if (clr_underrun_i) begin
      underrun_d = 1'b0;
    end

    if (!en_i) begin
      ph_d = '0;
    end else if (ce_i) begin
      ph_d = (ph_q == PhW'(OSR - 1)) ? '0 : ph_q + PhW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ph_q       <= '0;
      buf_full_q <= 1'b0;
      nxt_q      <= '0;
      cur_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      ph_q       <= ph_d;
      buf_full_q <= buf_full_d;
      nxt_q      <= nxt_d;
      cur_q      <= cur_d;
      underrun_q <= underrun_d;
    end
  end

  // cur_d feeds the core so a freshly loaded sample is used on its load tick.
  sd_mod2_core #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_core (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .step_i   (run),
    .clear_i  (~en_i),
    .toggle_i (ce_i & ~en_i),
    .x_i      (cur_d),
    .bs_o     (bs_o)
  );

  assign din_ready_o   = ~buf_full_q;
  assign frame_start_o = boundary;
  assign underrun_o    = underrun_q;

endmodule
